// File: rtl/cpu_pkg.sv
// Shared types and sizing helpers for the memory address register sequencer (mar_seq).
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } mar_state_t;

  localparam int unsigned MAR_TIMEOUT_DEFAULT = 15;

  // The counter must be able to hold TIMEOUT itself, hence the +1.
  function automatic int unsigned cnt_width(input int unsigned timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

  localparam int unsigned MAR_CNT_W = cnt_width(MAR_TIMEOUT_DEFAULT);

endpackage

// File: rtl/mar_addr_unit.sv
// Address register with set > add_off > inc priority and modulo-2**AW arithmetic.
module mar_addr_unit
  import cpu_pkg::*;
#(
  parameter int unsigned AW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          upd_en,
  input  logic          set,
  input  logic [AW-1:0] ALU_out,
  input  logic          add_off,
  input  logic [AW-1:0] offset,
  input  logic          inc,
  input  logic          bump,
  output logic [AW-1:0] addr_o
);

  logic [AW-1:0] addr_q, addr_d;

  // Updates from the control unit only count when the sequencer is idle; bump is the post-access increment.
  always_comb begin
    addr_d = addr_q;
    if (upd_en) begin
      if (set) begin
        addr_d = ALU_out;
      end else if (add_off) begin
        addr_d = addr_q + offset;
      end else if (inc) begin
        addr_d = addr_q + AW'(1);
      end
    end else if (bump) begin
      addr_d = addr_q + AW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

  assign addr_o = addr_q;

endmodule

// File: rtl/mar_seq.sv
// Memory address register with a single-outstanding read/write handshake and timeout.
// Define MAR_BOUND_CHECK_EN to reject accesses above ADDR_LIMIT and expose bound_fault.
module mar_seq
  import cpu_pkg::*;
#(
  parameter int unsigned AW         = 8,
  parameter int unsigned AUTO_INC   = 0,
  parameter int unsigned TIMEOUT    = MAR_TIMEOUT_DEFAULT,
  parameter int unsigned ADDR_LIMIT = 2**AW - 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          set,
  input  logic [AW-1:0] ALU_out,
  input  logic          inc,
  input  logic          add_off,
  input  logic [AW-1:0] offset,
  input  logic          start,
  input  logic          wr,
  output logic          mem_req,
  output logic          mem_we,
  input  logic          mem_ack,
  output logic [AW-1:0] Address_bus,
  output logic          busy,
  output logic          done,
  output logic          err
`ifdef MAR_BOUND_CHECK_EN
  ,
  output logic          bound_fault
`endif
);

  localparam int unsigned CW = (TIMEOUT == MAR_TIMEOUT_DEFAULT) ? MAR_CNT_W : cnt_width(TIMEOUT);

  if (AW < 4 || AW > 16 || TIMEOUT < 1 || TIMEOUT > 255 || ADDR_LIMIT > (2**AW - 1)) begin : g_param_check
    $error("mar_seq: illegal parameter combination");
  end

  mar_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          we_q, we_d;
  logic          in_idle;
  logic          bound_hit;

  assign in_idle = (state_q == IDLE);

`ifdef MAR_BOUND_CHECK_EN
  assign bound_hit = (32'(Address_bus) > ADDR_LIMIT);
`else
  assign bound_hit = 1'b0;
`endif

  mar_addr_unit #(
    .AW(AW)
  ) u_addr (
    .clk     (clk),
    .rst_n   (rst_n),
    .upd_en  (in_idle),
    .set     (set),
    .ALU_out (ALU_out),
    .add_off (add_off),
    .offset  (offset),
    .inc     (inc),
    .bump    ((state_q == DONE) && (AUTO_INC != 0)),
    .addr_o  (Address_bus)
  );

  // An ack in the same cycle the counter hits TIMEOUT wins over the timeout.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          we_d    = wr;
          cnt_d   = '0;
          state_d = bound_hit ? ERR : REQ;
        end
      end
      REQ: begin
        if (mem_ack) begin
          state_d = DONE;
        end else if (cnt_q == CW'(TIMEOUT)) begin
          state_d = ERR;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      ERR: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
    end
  end

  assign mem_req = (state_q == REQ);
  assign mem_we  = we_q & mem_req;
  assign busy    = ~in_idle;
  assign done    = (state_q == DONE);
  assign err     = (state_q == ERR);

`ifdef MAR_BOUND_CHECK_EN
  logic bound_fault_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bound_fault_q <= 1'b0;
    end else if (in_idle && start && bound_hit) begin
      bound_fault_q <= 1'b1;
    end else if (in_idle && set) begin
      bound_fault_q <= 1'b0;
    end
  end

  assign bound_fault = bound_fault_q;
`endif

endmodule

// File: tb/tb_mar_seq.sv
// Scoreboard bench for mar_seq (AW=8, AUTO_INC=1, TIMEOUT=3, ADDR_LIMIT=0x7F).
module tb_mar_seq;

  localparam int TO    = 3;
  localparam int LIMIT = 8'h7F;
`ifdef MAR_BOUND_CHECK_EN
  localparam bit BOUND_ON = 1'b1;
`else
  localparam bit BOUND_ON = 1'b0;
`endif

  typedef struct {
    bit         isDone;
    logic [7:0] addr;
    bit         we;
    int         reqCycles;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       set = 1'b0, inc = 1'b0, add_off = 1'b0, start = 1'b0, wr = 1'b0, mem_ack = 1'b0;
  logic [7:0] ALU_out = '0, offset = '0;
  logic       mem_req, mem_we, busy, done, err;
  logic [7:0] Address_bus;
`ifdef MAR_BOUND_CHECK_EN
  logic       bound_fault;
`endif

  int         checks = 0;
  int         passes = 0;
  exp_t       expQ[$];
  logic [7:0] modelAddr = '0;
  int         ackDelay = 0;
  int         reqCnt = 0;
  int         seen = 0;
  bit         prevReq = 1'b0;
  logic [7:0] seenAddr = '0;
  bit         seenWe = 1'b0;

  mar_seq #(
    .AW(8), .AUTO_INC(1), .TIMEOUT(TO), .ADDR_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .set(set), .ALU_out(ALU_out), .inc(inc),
    .add_off(add_off), .offset(offset), .start(start), .wr(wr),
    .mem_req(mem_req), .mem_we(mem_we), .mem_ack(mem_ack),
    .Address_bus(Address_bus), .busy(busy), .done(done), .err(err)
`ifdef MAR_BOUND_CHECK_EN
    , .bound_fault(bound_fault)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  // Reference address arithmetic: priority set > add_off > inc, modulo 256.
  function automatic logic [7:0] nextAddr(input logic [7:0] a, input bit s, input logic [7:0] alu,
                                          input bit ao, input logic [7:0] o, input bit i);
    if (s) return alu;
    if (ao) return 8'((int'(a) + int'(o)) % 256);
    if (i) return 8'((int'(a) + 1) % 256);
    return a;
  endfunction

  // Drives one cycle of inputs starting at a falling edge, then returns them to idle.
  task automatic applyStimulus(input bit s, input logic [7:0] a, input bit ao, input logic [7:0] o,
                               input bit i, input bit st, input bit w);
    set = s; ALU_out = a; add_off = ao; offset = o; inc = i; start = st; wr = w;
    @(negedge clk);
    set = 1'b0; add_off = 1'b0; inc = 1'b0; start = 1'b0; wr = 1'b0;
  endtask

  task automatic doUpdate(input bit s, input logic [7:0] a, input bit ao, input logic [7:0] o, input bit i);
    modelAddr = nextAddr(modelAddr, s, a, ao, o, i);
    applyStimulus(s, a, ao, o, i, 1'b0, 1'b0);
    checkOutput("addr_update", Address_bus, modelAddr);
  endtask

  task automatic doAccess(input int delay, input bit w, input bit junk, input bit allowUpd);
    bit s, ao, i;
    logic [7:0] a, o;
    exp_t e;
    int guard;
    s  = allowUpd && !BOUND_ON && ($urandom_range(0, 3) == 0);
    ao = allowUpd && !BOUND_ON && ($urandom_range(0, 3) == 0);
    i  = allowUpd && !BOUND_ON && ($urandom_range(0, 3) == 0);
    a  = 8'($urandom);
    o  = 8'($urandom);
    ackDelay = delay;
    modelAddr = nextAddr(modelAddr, s, a, ao, o, i);
    e.addr = modelAddr;
    e.we   = w;
    if (BOUND_ON && int'(modelAddr) > LIMIT) begin
      e.isDone = 1'b0; e.reqCycles = 0;
    end else if (delay <= TO) begin
      e.isDone = 1'b1; e.reqCycles = delay + 1;
      modelAddr = 8'((int'(modelAddr) + 1) % 256);
    end else begin
      e.isDone = 1'b0; e.reqCycles = TO + 1;
    end
    expQ.push_back(e);
    applyStimulus(s, a, ao, o, i, 1'b1, w);
    guard = 0;
    while (busy && guard < 40) begin
      if (junk) begin
        set = 1'b1; ALU_out = 8'h55; inc = 1'b1; add_off = 1'b1; offset = 8'($urandom);
        start = 1'b1; wr = ~w;
      end
      @(negedge clk);
      set = 1'b0; inc = 1'b0; add_off = 1'b0; start = 1'b0; wr = 1'b0;
      guard++;
    end
    checkOutput("access_ends", busy, 1'b0);
    checkOutput("addr_after_access", Address_bus, modelAddr);
  endtask

  // Memory model: acks after ackDelay request cycles, and sprays stray acks while idle.
  initial begin
    forever begin
      @(negedge clk);
      if (mem_req) begin
        mem_ack = (reqCnt == ackDelay);
        reqCnt++;
      end else begin
        reqCnt = 0;
        mem_ack = ($urandom_range(0, 3) == 0);
      end
    end
  end

  // Monitor: tracks each request window and pops the scoreboard on every done/err pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        seen = 0;
        prevReq = 1'b0;
      end else begin
        if (mem_req) begin
          if (seen > 0) begin
            checkOutput("addr_stable_in_req", Address_bus, seenAddr);
          end
          seenAddr = Address_bus;
          seenWe = mem_we;
          seen++;
        end
        checkOutput("done_err_exclusive", done & err, 1'b0);
        if (done || err) begin
          checkOutput("pulse_expected", expQ.size() > 0, 1'b1);
          if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput("done_pulse", done, e.isDone);
            checkOutput("err_pulse", err, !e.isDone);
            checkOutput("req_cycles", seen, e.reqCycles);
            checkOutput("pulse_after_req", prevReq, e.reqCycles > 0);
            if (e.reqCycles > 0) begin
              checkOutput("req_addr", seenAddr, e.addr);
              checkOutput("req_we", seenWe, e.we);
            end
          end
          seen = 0;
        end
        prevReq = mem_req;
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_addr", Address_bus, 8'h00);
    checkOutput("reset_req", mem_req, 1'b0);
    checkOutput("reset_we", mem_we, 1'b0);
    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_done", done, 1'b0);
    checkOutput("reset_err", err, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    doUpdate(1'b1, 8'hFF, 1'b0, 8'h00, 1'b1);
    doUpdate(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    doUpdate(1'b0, 8'h00, 1'b1, 8'hFE, 1'b0);
    doUpdate(1'b0, 8'h00, 1'b1, 8'h03, 1'b1);

    doUpdate(1'b1, 8'h10, 1'b0, 8'h00, 1'b0);
    doAccess(0, 1'b0, 1'b0, 1'b0);
    checkOutput("auto_inc_addr", Address_bus, 8'h11);
    doAccess(9, 1'b1, 1'b0, 1'b0);
    doAccess(TO, 1'b1, 1'b0, 1'b0);
    doAccess(TO + 1, 1'b0, 1'b0, 1'b0);
    doAccess(1, 1'b1, 1'b1, 1'b0);
    doAccess(9, 1'b0, 1'b1, 1'b0);

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 1) == 0) begin
        doUpdate(1'($urandom), 8'($urandom), 1'($urandom), 8'($urandom), 1'($urandom));
      end else begin
        doAccess($urandom_range(0, 5), 1'($urandom), 1'($urandom), 1'b1);
      end
    end

    doUpdate(1'b1, 8'h3C, 1'b0, 8'h00, 1'b0);
    ackDelay = 100;
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("req_before_reset", mem_req, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("abort_req", mem_req, 1'b0);
    checkOutput("abort_busy", busy, 1'b0);
    checkOutput("abort_addr", Address_bus, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    modelAddr = 8'h00;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      checkOutput("no_pulse_after_reset", done | err, 1'b0);
    end

`ifdef MAR_BOUND_CHECK_EN
    doUpdate(1'b1, 8'h80, 1'b0, 8'h00, 1'b0);
    doAccess(0, 1'b0, 1'b0, 1'b0);
    checkOutput("bound_fault_set", bound_fault, 1'b1);
    doUpdate(1'b1, 8'h00, 1'b0, 8'h00, 1'b0);
    checkOutput("bound_fault_clear", bound_fault, 1'b0);
`endif

    repeat (4) @(negedge clk);
    checkOutput("queue_drained", expQ.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/mar_seq.md
Name: mar_seq

Overview:
- Parametrised memory address register with a built-in single-outstanding memory-access handshake.
- Holds the current address, which can be loaded from the ALU, incremented, or offset-added.
- Issues read/write requests to data memory, with timeout and optional post-access auto-increment.
- Sits between the ALU output and the memory address bus; the control unit drives it.

Parameters:
- AW, 8, address width in bits (legal range 4..16).
- AUTO_INC, 0, 1 = address increments by 1 after each acknowledged access.
- TIMEOUT, 15, max cycles in REQ awaiting mem_ack before error (1..255).
- ADDR_LIMIT, 2**AW-1, highest legal address; used only with MAR_BOUND_CHECK_EN.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- set  in  1  load address from ALU_out.
- ALU_out  in  AW  ALU result to load.
- inc  in  1  address <= address + 1.
- add_off  in  1  address <= address + offset.
- offset  in  AW  two's-complement offset.
- start  in  1  begin memory access at current address.
- wr  in  1  access direction sampled with start (1 = write).
- mem_req  out  1  request to memory.
- mem_we  out  1  write enable, valid while mem_req.
- mem_ack  in  1  memory acknowledge.
- Address_bus  out  AW  current address register.
- busy  out  1  FSM not IDLE.
- done  out  1  one-cycle pulse on acknowledged access.
- err  out  1  one-cycle pulse on timeout or bound fault.

Behaviour:
- Reset (async assert, sync release): Address_bus=0, mem_req=0, mem_we=0, busy=0, done=0, err=0, FSM=IDLE, timeout counter=0.
- Address updates apply only in IDLE, one per cycle, priority set > add_off > inc; lower-priority requests that cycle are dropped.
- set/inc/add_off are ignored while busy, so the address is stable during an access.
- Arithmetic is modulo 2**AW, truncated: 0xFF+1=0x00 and 0x02+0xFD=0xFF at AW=8. No carry or overflow flag.
- FSM states: IDLE, REQ, DONE, ERR.
- IDLE -> REQ on start. wr is latched into mem_we. Any same-cycle update takes effect first, so the request uses the updated address.
- REQ: mem_req=1, busy=1, counter increments each cycle.
  - mem_ack seen -> DONE.
  - Otherwise, when counter reaches TIMEOUT -> ERR.
  - The counter value on entry to REQ is 0.
  - mem_ack in the same cycle the counter hits TIMEOUT counts as success.
- DONE (1 cycle): done=1, mem_req=0; if AUTO_INC, address += 1 (wraps). Then -> IDLE.
- ERR (1 cycle): err=1, mem_req=0, address unchanged. Then -> IDLE.
- Latency with immediate ack:
  - start at cycle 0; mem_req high at cycle 1.
  - ack at cycle 1; done at cycle 2.
  - IDLE and new start accepted at cycle 3.
- start while busy is ignored, with no queuing.
- mem_ack outside REQ is ignored.
- rst_n low mid-access aborts immediately: mem_req drops asynchronously and no done/err pulse is produced.

Optional Feature:
- Macro MAR_BOUND_CHECK_EN.
- When defined: start with Address_bus > ADDR_LIMIT goes IDLE -> ERR with no mem_req ever asserted. This adds a sticky output bound_fault (1 bit, reset 0), set on that event and cleared by the next set.
- When undefined: no limit comparison, no bound_fault port, ADDR_LIMIT unused.

Decomposition:
- Shared package cpu_pkg holds:
  - FSM state enum mar_state_t (IDLE, REQ, DONE, ERR).
  - Localparam for the timeout counter width, $clog2(TIMEOUT+1).
- Natural sub-module: mar_addr_unit, the address register with the set/add_off/inc priority mux and modulo adder. The top level owns the FSM and timeout counter.

Test Plan:
- Reset mid-REQ: assert rst_n=0 while mem_req=1 -> mem_req, busy, Address_bus go 0 the same cycle; no done/err after release.
- Priority and wrap (AW=8): set=1, inc=1, ALU_out=0xFF -> Address_bus=0xFF; then inc -> 0x00; then add_off, offset=0xFE -> 0xFE.
- Read handshake, AUTO_INC=1: Address_bus=0x10, start, wr=0, ack one cycle after mem_req:
  - mem_req high exactly 1 cycle with address 0x10, mem_we=0.
  - done pulse on the next cycle.
  - Address_bus=0x11 afterwards.
- Timeout, TIMEOUT=3: start, never ack -> mem_req high 4 cycles, then err pulse 1 cycle, address unchanged, busy low after.
- Ignore while busy: during REQ drive set with ALU_out=0x55, and inc, and start -> Address_bus unchanged, one access only.
- With MAR_BOUND_CHECK_EN and ADDR_LIMIT=0x7F: set 0x80, start -> no mem_req, err pulse, bound_fault=1; set 0x00 -> bound_fault=0.
